// File: rtl/display_code_sequencer.sv
// display_code_sequencer: generates the 4-bit code for the display decoder.
//   The code steps up or down on a push-button press (manual mode) or on a
//   prescaled timer tick (auto mode). It supports synchronous load and wraps
//   between MAX_CODE and 0.
//   Optional feature macro: DISPLAY_SEQ_DEBOUNCE_EN adds a debounce filter on
//   the synchronized button.
//   Ports:
//     clk, rst_n   - rising-edge clock, asynchronous active-low reset
//     enable       - 1 allows advancing, 0 holds the code
//     auto_mode    - 1 steps on the timer, 0 steps on the button
//     up_down      - 1 counts up, 0 counts down
//     step_btn     - raw asynchronous push-button, active high
//     load         - synchronous load strobe
//     load_value   - value to load, saturated to MAX_CODE
//     input_code   - code to the decoder
//     code_strobe  - one-cycle pulse with every code update
//     wrap         - one-cycle pulse with an update that wrapped
module display_code_sequencer #(
   parameter int MAX_CODE        = 15,
   parameter int PRESCALE        = 1000,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       auto_mode,
   input  logic       up_down,
   input  logic       step_btn,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic [3:0] input_code,
   output logic       code_strobe,
   output logic       wrap
);
   localparam int             PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [3:0]     MAX      = 4'(MAX_CODE);
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_hist;
   logic [PW-1:0] r_pre;
   logic          w_lvl;
   logic          w_pulse;
   logic          w_tick;
   logic          w_adv;
   logic          w_end;
   logic [3:0]    w_next;
   logic [3:0]    w_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= step_btn;
         r_s2 <= r_s1;
      end
   end

`ifdef DISPLAY_SEQ_DEBOUNCE_EN
   localparam int            DW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          r_db;
   logic [DW-1:0] r_db_cnt;

   // db follows s2 only after s2 has differed from it for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db     <= 1'b0;
         r_db_cnt <= '0;
      end else if (r_s2 == r_db) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
         r_db     <= r_s2;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   assign w_lvl = r_db;
`else
   assign w_lvl = r_s2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_hist <= 1'b0;
      else        r_hist <= w_lvl;
   end

   assign w_pulse = w_lvl & ~r_hist;

   // prescaler runs only in auto mode, freezes while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_pre <= '0;
      else if (!auto_mode) r_pre <= '0;
      else if (enable)     r_pre <= w_tick ? '0 : r_pre + 1'b1;
   end

   assign w_tick = auto_mode & (r_pre == PRE_LAST);
   assign w_adv  = enable & (auto_mode ? w_tick : w_pulse);
   assign w_end  = up_down ? (input_code == MAX) : (input_code == 4'd0);
   assign w_next = up_down ? (w_end ? 4'd0 : input_code + 4'd1)
                           : (w_end ? MAX  : input_code - 4'd1);
   assign w_load = (load_value > MAX) ? MAX : load_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         input_code  <= 4'd0;
         code_strobe <= 1'b0;
         wrap        <= 1'b0;
      end else begin
         code_strobe <= load | w_adv;
         wrap        <= ~load & w_adv & w_end;
         if (load)       input_code <= w_load;
         else if (w_adv) input_code <= w_next;
      end
   end
endmodule

// File: tb/tb_display_code_sequencer.sv
// tb_display_code_sequencer: scoreboard bench for display_code_sequencer.
module tb_display_code_sequencer;
   localparam int MAXC = 9;
   localparam int PRE  = 4;
   localparam int DB   = 4;
`ifdef DISPLAY_SEQ_DEBOUNCE_EN
   localparam int LAT = DB + 3;
`else
   localparam int LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       auto_mode = 1'b0;
   logic       up_down = 1'b0;
   logic       step_btn = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_value = 4'd0;
   logic [3:0] input_code;
   logic       code_strobe;
   logic       wrap;

   typedef struct {
      int c;
      int code;
      bit w;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   t;

   display_code_sequencer #(
      .MAX_CODE(MAXC), .PRESCALE(PRE), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .auto_mode(auto_mode),
      .up_down(up_down), .step_btn(step_btn), .load(load),
      .load_value(load_value), .input_code(input_code),
      .code_strobe(code_strobe), .wrap(wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic exp_at(input int c, input int code, input bit w);
      q.push_back('{c, code, w});
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor: every strobe must match the oldest expected update, including its edge number
   always @(negedge clk) begin
      if (rst_n) begin
         if (code_strobe) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected strobe: code %0d wrap %0d at cycle %0d", input_code, wrap, cyc);
            end else begin
               e = q.pop_front();
               chk("update cycle", cyc, e.c);
               chk("update code", input_code, e.code);
               chk("update wrap", wrap, e.w);
            end
         end else if (wrap) begin
            n_vec++;
            n_err++;
            $display("FAIL wrap without strobe: got 1, expected 0 at cycle %0d", cyc);
         end
      end
   end

   initial begin
      wait_neg(3);
      chk("reset code", input_code, 0);
      chk("reset strobe", code_strobe, 0);
      chk("reset wrap", wrap, 0);
      // auto count up through the wrap
      rst_n = 1'b1; auto_mode = 1'b1; enable = 1'b1; up_down = 1'b1;
      t = cyc;
      for (int k = 1; k <= 10; k++) exp_at(t + 4 * k, k % 10, k == 10);
      wait_neg(40);
      // manual mode: press while disabled is dropped
      auto_mode = 1'b0; up_down = 1'b0; enable = 1'b0; step_btn = 1'b1;
      wait_neg(5);
      step_btn = 1'b0;
      wait_neg(12);
      enable = 1'b1;
      t = cyc;
      step_btn = 1'b1;
      exp_at(t + LAT, 9, 1'b1);
      wait_neg(10);
      step_btn = 1'b0;
      wait_neg(12);
`ifdef DISPLAY_SEQ_DEBOUNCE_EN
      step_btn = 1'b1;
      wait_neg(2);
      step_btn = 1'b0;
      wait_neg(10);
      t = cyc;
      step_btn = 1'b1;
      exp_at(t + LAT, 8, 1'b0);
      wait_neg(8);
      step_btn = 1'b0;
      wait_neg(12);
`endif
      // load saturates and rewrites
      t = cyc;
      load = 1'b1; load_value = 4'd12;
      exp_at(t + 1, 9, 1'b0);
      wait_neg(1);
      load = 1'b0;
      // load collides with a tick
      t = cyc;
      auto_mode = 1'b1; up_down = 1'b1;
      exp_at(t + 4, 5, 1'b0);
      wait_neg(3);
      load = 1'b1; load_value = 4'd5;
      wait_neg(1);
      load = 1'b0;
      exp_at(t + 8, 6, 1'b0);
      wait_neg(5);
      // disabled in auto mode: prescaler held at 1
      enable = 1'b0; step_btn = 1'b1;
      wait_neg(5);
      step_btn = 1'b0;
      wait_neg(15);
      enable = 1'b1;
      exp_at(t + 32, 7, 1'b0);
      wait_neg(4);
      up_down = 1'b0;
      exp_at(t + 36, 6, 1'b0);
      wait_neg(5);
      // asynchronous reset mid-count at code 6
      #2 rst_n = 1'b0;
      #1 chk("async reset code", input_code, 0);
      chk("async reset strobe", code_strobe, 0);
      wait_neg(2);
      rst_n = 1'b1; up_down = 1'b1;
      t = cyc;
      exp_at(t + 4, 1, 1'b0);
      exp_at(t + 8, 2, 1'b0);
      wait_neg(9);
      auto_mode = 1'b0;
      wait_neg(4);
      chk("pending updates", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
